// File: rtl/rvga_mem_arbiter.sv
// rvga_mem_arbiter: shares one cacheline memory port between I-fetch and D-load/store.
// Optional RVGA_ARB_RR_EN selects round-robin arbitration instead of D-over-I priority.
module rvga_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_rd;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic                w_req_i;
  logic                w_req_d;
  logic                w_pick_d;
  logic                w_gnt_i;
  logic                w_gnt_d;
  logic                w_done;

  assign w_req_i = i_read;
  assign w_req_d = d_read | d_write;
  assign w_done  = (r_state != IDLE) & pmem_resp;

`ifdef RVGA_ARB_RR_EN
  logic r_last_d;

  // On a tie, D wins only if I was the last one granted
  always_comb begin
    w_pick_d = w_req_d & (~w_req_i | ~r_last_d);
  end

  // Remember which requester won the most recent grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (w_gnt_d) begin
      r_last_d <= 1'b1;
    end else if (w_gnt_i) begin
      r_last_d <= 1'b0;
    end
  end
`else
  // D always wins a tie
  always_comb begin
    w_pick_d = w_req_d;
  end
`endif

  // Next-state and grant decode
  always_comb begin
    w_next  = r_state;
    w_gnt_i = 1'b0;
    w_gnt_d = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_next  = SERVE_D;
          w_gnt_d = 1'b1;
        end else if (w_req_i) begin
          w_next  = SERVE_I;
          w_gnt_i = 1'b1;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch owner request at grant; strobes drop with the completion edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_gnt_d) begin
      r_addr  <= d_address;
      r_wdata <= d_wdata;
      r_wr    <= d_write;
      r_rd    <= ~d_write;
    end else if (w_gnt_i) begin
      r_addr  <= i_address;
      r_wr    <= 1'b0;
      r_rd    <= 1'b1;
    end else if (w_done) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end
  end

  assign pmem_read    = r_rd;
  assign pmem_write   = r_wr;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  assign i_resp  = (r_state == SERVE_I) & pmem_resp;
  assign d_resp  = (r_state == SERVE_D) & pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// tb_rvga_mem_arbiter: directed scenarios plus randomized I/D traffic
// against a memory model, with a queue-based response scoreboard.
module tb_rvga_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_address;
  logic         i_resp;
  logic [127:0] i_rdata;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [127:0] d_wdata;
  logic         d_resp;
  logic [127:0] d_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  always #5 clk = ~clk;

  rvga_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_resp       (i_resp),
    .i_rdata      (i_rdata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_resp       (d_resp),
    .d_rdata      (d_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  typedef struct {
    logic         wr;
    logic [127:0] data;
  } dexp_t;

  int           checks = 0;
  int           errors = 0;
  int           i_cnt  = 0;
  int           d_cnt  = 0;
  bit           done   = 0;
  logic [127:0] qi[$];
  dexp_t        qd[$];
  logic [127:0] dm[logic [31:0]];
  logic [127:0] pm[logic [31:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b required %b", n, a, e);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, a, e);
    end
  endtask

  task automatic chk128(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, a, e);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_A5A5, a + 32'h0123_4567};
  endfunction

  task automatic chk_quiet(input string n);
    chk1({n, "_rd"}, pmem_read, 1'b0);
    chk1({n, "_wr"}, pmem_write, 1'b0);
  endtask

  // Randomized I requester: line reads from its own region
  task automatic drive_i(input int n);
    logic [31:0] r;
    int          start;
    int          t;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      r = $urandom;
      i_address = {16'h1000, r[15:0]};
      qi.push_back(line_of(i_address));
      i_read = 1'b1;
      start = i_cnt;
      t = 0;
      while (i_cnt == start && t < 300) begin
        tick();
        t++;
      end
      if (i_cnt == start) begin
        checks++;
        errors++;
        $display("FAIL i_timeout: got no i_resp required i_resp within 300 cycles");
      end
      i_read = 1'b0;
    end
  endtask

  // Randomized D requester: reads, writes and read+write over a small line set
  task automatic drive_d(input int n);
    int          op;
    int          start;
    int          t;
    logic [31:0] a;
    logic [127:0] w;
    dexp_t       e;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      op = $urandom_range(0, 2);
      a = 32'hD000_0000 + 32'($urandom_range(0, 7)) * 32'd16;
      w = {$urandom, $urandom, $urandom, $urandom};
      d_address = a;
      d_wdata = w;
      d_read = (op != 1);
      d_write = (op != 0);
      if (op != 0) begin
        dm[a] = w;
        e.wr = 1'b1;
        e.data = '0;
      end else begin
        e.wr = 1'b0;
        e.data = dm.exists(a) ? dm[a] : line_of(a);
      end
      qd.push_back(e);
      start = d_cnt;
      t = 0;
      while (d_cnt == start && t < 300) begin
        tick();
        t++;
      end
      if (d_cnt == start) begin
        checks++;
        errors++;
        $display("FAIL d_timeout: got no d_resp required d_resp within 300 cycles");
      end
      d_read = 1'b0;
      d_write = 1'b0;
    end
  endtask

  // Physical memory with random response latency; checks strobe stability
  task automatic mem_model();
    bit           busy = 0;
    int           wc = 0;
    logic [31:0]  a = '0;
    logic [127:0] w = '0;
    logic         wr = 1'b0;
    while (!done) begin
      tick();
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      if (pmem_read || pmem_write) begin
        if (!busy) begin
          chk1("mem_onehot", pmem_read ^ pmem_write, 1'b1);
          busy = 1;
          a = pmem_address;
          w = pmem_wdata;
          wr = pmem_write;
          wc = $urandom_range(0, 3);
        end else begin
          chk32("mem_addr_hold", pmem_address, a);
          chk1("mem_op_hold", pmem_write, wr);
          if (wr) chk128("mem_wdata_hold", pmem_wdata, w);
        end
        if (wc == 0) begin
          pmem_resp = 1'b1;
          busy = 0;
          if (wr) pm[a] = w;
          else pmem_rdata = pm.exists(a) ? pm[a] : line_of(a);
        end else begin
          wc--;
        end
      end
    end
    pmem_resp = 1'b0;
    pmem_rdata = '0;
  endtask

  // Scoreboard: pops expected responses whenever the DUT signals completion
  task automatic monitor();
    logic [127:0] ei;
    dexp_t        ed;
    while (!done) begin
      @(negedge clk);
      if (i_resp) begin
        chk1("i_excl", d_resp, 1'b0);
        chk128("i_other_rdata", d_rdata, '0);
        if (qi.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL i_unexpected: got i_resp required none");
        end else begin
          ei = qi.pop_front();
          chk128("i_rdata", i_rdata, ei);
        end
        i_cnt++;
      end
      if (d_resp) begin
        chk128("d_other_rdata", i_rdata, '0);
        if (qd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d_unexpected: got d_resp required none");
        end else begin
          ed = qd.pop_front();
          if (!ed.wr) chk128("d_rdata", d_rdata, ed.data);
        end
        d_cnt++;
      end
      if (!i_resp && !d_resp) begin
        chk128("rdata_quiet", i_rdata | d_rdata, '0);
      end
    end
  endtask

  logic exp_d;

  initial begin
    rst = 1'b1;
    i_read = 1'b0;
    i_address = '0;
    d_read = 1'b0;
    d_write = 1'b0;
    d_address = '0;
    d_wdata = '0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    tick();
    tick();
    chk_quiet("rst");
    chk32("rst_addr", pmem_address, 32'h0);
    chk128("rst_wdata", pmem_wdata, '0);
    chk1("rst_iresp", i_resp, 1'b0);
    chk1("rst_dresp", d_resp, 1'b0);
    rst = 1'b0;
    tick();

    // I line read
    i_read = 1'b1;
    i_address = 32'h0001_0054;
    tick();
    chk1("t1_rd", pmem_read, 1'b1);
    chk1("t1_wr", pmem_write, 1'b0);
    chk32("t1_addr", pmem_address, 32'h0001_0054);
    tick();
    tick();
    pmem_resp = 1'b1;
    pmem_rdata = {16{8'hA5}};
    #1;
    chk1("t1_iresp", i_resp, 1'b1);
    chk128("t1_irdata", i_rdata, {16{8'hA5}});
    chk1("t1_dresp", d_resp, 1'b0);
    chk128("t1_drdata", d_rdata, '0);
    tick();
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    i_read = 1'b0;
    #1;
    chk_quiet("t1_drop");
    chk1("t1_iresp_pulse", i_resp, 1'b0);

    // D write, requester changes address/data mid-transaction
    tick();
    d_write = 1'b1;
    d_address = 32'h2000;
    d_wdata = 128'h1234;
    tick();
    chk1("t2_wr", pmem_write, 1'b1);
    chk1("t2_rd", pmem_read, 1'b0);
    chk32("t2_addr", pmem_address, 32'h2000);
    chk128("t2_wdata", pmem_wdata, 128'h1234);
    d_address = 32'h3000;
    d_wdata = 128'hFFFF;
    tick();
    chk32("t4_addr_latched", pmem_address, 32'h2000);
    chk128("t2_wdata_latched", pmem_wdata, 128'h1234);
    chk1("t2_rd_never", pmem_read, 1'b0);
    pmem_resp = 1'b1;
    #1;
    chk1("t2_dresp", d_resp, 1'b1);
    chk1("t2_iresp", i_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    d_write = 1'b0;
    #1;
    chk_quiet("t2_drop");

    // Stray pmem_resp while IDLE
    tick();
    pmem_resp = 1'b1;
    pmem_rdata = '1;
    #1;
    chk1("t4_stray_i", i_resp, 1'b0);
    chk1("t4_stray_d", d_resp, 1'b0);
    chk128("t4_stray_rdata", i_rdata | d_rdata, '0);
    tick();
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    chk_quiet("t4_idle");

    // Tie arbitration, both requesters re-requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_read = 1'b1;
    i_address = 32'h100;
    d_read = 1'b1;
    d_address = 32'h200;
    for (int k = 0; k < 4; k++) begin
      tick();
`ifdef RVGA_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      chk32("t3_owner_addr", pmem_address, exp_d ? 32'h200 : 32'h100);
      pmem_resp = 1'b1;
      #1;
      chk1("t3_dresp", d_resp, exp_d);
      chk1("t3_iresp", i_resp, ~exp_d);
      tick();
      pmem_resp = 1'b0;
      #1;
      chk_quiet("t3_gap");
    end
    i_read = 1'b0;
    d_read = 1'b0;

    // Reset during SERVE_D, then stray completion
    tick();
    d_read = 1'b1;
    d_address = 32'h4000;
    tick();
    chk1("t5_rd", pmem_read, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d_read = 1'b0;
    chk_quiet("t5_after_rst");
    pmem_resp = 1'b1;
    #1;
    chk1("t5_no_dresp", d_resp, 1'b0);
    chk1("t5_no_iresp", i_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    chk_quiet("t5_idle");

    // Read+write treated as write; one IDLE cycle between grants
    d_read = 1'b1;
    d_write = 1'b1;
    d_address = 32'h5000;
    d_wdata = 128'hBEEF;
    tick();
    chk1("t6_wr", pmem_write, 1'b1);
    chk1("t6_rd", pmem_read, 1'b0);
    pmem_resp = 1'b1;
    #1;
    chk1("t6_dresp", d_resp, 1'b1);
    tick();
    pmem_resp = 1'b0;
    chk_quiet("t6_gap");
    tick();
    chk1("t6_regrant", pmem_write, 1'b1);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
    tick();

    // Randomized concurrent traffic
    done = 0;
    fork
      begin
        fork
          drive_i(40);
          drive_d(40);
        join
        done = 1;
      end
      mem_model();
      monitor();
    join
    chk32("qi_empty", 32'(qi.size()), 32'd0);
    chk32("qd_empty", 32'(qd.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
